// File: rtl/uart_seq_trig_rx_pkg.sv
// Shared types for the UART sequence-trigger receiver.
package uart_trig_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_seq_trig_rx_if.sv
// Bundle of RX line, config inputs and receiver/trigger outputs.
interface uart_seq_trig_rx_if #(
  parameter int DATA_BITS = 8,
  parameter int SEQ_LEN   = 2,
  parameter int BAUD_W    = 16
);
  localparam int POS_W = $clog2(SEQ_LEN + 1);

  logic                         RX;
  logic [BAUD_W-1:0]            baud_cnt;
  logic                         parity_odd;
  logic                         arm;
  logic [SEQ_LEN*DATA_BITS-1:0] match;
  logic [SEQ_LEN*DATA_BITS-1:0] mask;
  logic [DATA_BITS-1:0]         rx_data;
  logic                         rx_valid;
  logic                         frame_err;
  logic                         parity_err;
  logic [POS_W-1:0]             seq_pos;
  logic                         UARTtrig;

  modport master (
    output RX, baud_cnt, parity_odd, arm, match, mask,
    input  rx_data, rx_valid, frame_err, parity_err, seq_pos, UARTtrig
  );

  modport slave (
    input  RX, baud_cnt, parity_odd, arm, match, mask,
    output rx_data, rx_valid, frame_err, parity_err, seq_pos, UARTtrig
  );

endinterface

// File: rtl/uart_seq_trig_rx_core.sv
// UART frame receiver: 2-flop synchroniser, mid-bit sampling FSM, parity
// and stop checks; result pulses are registered one cycle after the stop sample.
module uart_rx_core
  import uart_trig_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 16,
  parameter int PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  input  logic [BAUD_W-1:0]    i_baud_cnt,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  localparam int BIT_W = $clog2(DATA_BITS);

  logic                 r_rx_meta, r_rx_s, r_rx_p;
  rx_state_t            r_state, w_state_n;
  logic [BAUD_W-1:0]    r_cnt, w_cnt_n;
  logic [BAUD_W-1:0]    r_baud_l, w_baud_n;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par_err, w_par_err_n;
  logic [DATA_BITS-1:0] r_data, w_data_n;
  logic                 r_valid, w_valid_n;
  logic                 r_frame_err, w_frame_err_n;
  logic                 r_parity_err, w_parity_err_n;
  logic [BAUD_W-1:0]    w_half_last, w_bit_last;
  logic                 w_par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_p    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_p    <= r_rx_s;
    end
  end

  // Terminal counts use the baud value latched at the start edge.
  assign w_half_last = (r_baud_l >> 1) - BAUD_W'(1);
  assign w_bit_last  = r_baud_l - BAUD_W'(1);
  assign w_par_bad   = ((^r_shift) ^ r_rx_s) != i_parity_odd;

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_baud_n       = r_baud_l;
    w_bit_n        = r_bit_cnt;
    w_shift_n      = r_shift;
    w_par_err_n    = r_par_err;
    w_data_n       = r_data;
    w_valid_n      = 1'b0;
    w_frame_err_n  = 1'b0;
    w_parity_err_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_rx_p && !r_rx_s) begin
          w_state_n   = START;
          w_cnt_n     = '0;
          w_baud_n    = i_baud_cnt;
          w_bit_n     = '0;
          w_par_err_n = 1'b0;
        end
      end
      START: begin
        if (r_cnt == w_half_last) begin
          w_cnt_n   = '0;
          w_state_n = r_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_n = r_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == w_bit_last) begin
          w_cnt_n   = '0;
          w_shift_n = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_n = r_bit_cnt + BIT_W'(1);
          end
        end else begin
          w_cnt_n = r_cnt + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (r_cnt == w_bit_last) begin
          w_cnt_n     = '0;
          w_par_err_n = w_par_bad;
          w_state_n   = STOP;
        end else begin
          w_cnt_n = r_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (r_cnt == w_bit_last) begin
          w_cnt_n        = '0;
          w_state_n      = IDLE;
          w_frame_err_n  = !r_rx_s;
          w_parity_err_n = r_par_err;
          if (r_rx_s && !r_par_err) begin
            w_valid_n = 1'b1;
            w_data_n  = r_shift;
          end
        end else begin
          w_cnt_n = r_cnt + BAUD_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_baud_l     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_baud_l     <= w_baud_n;
      r_bit_cnt    <= w_bit_n;
      r_shift      <= w_shift_n;
      r_par_err    <= w_par_err_n;
      r_data       <= w_data_n;
      r_valid      <= w_valid_n;
      r_frame_err  <= w_frame_err_n;
      r_parity_err <= w_parity_err_n;
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;

endmodule

// File: rtl/uart_seq_trig_rx.sv
// UART receiver plus masked multi-character sequence matcher; UARTtrig is
// combinational from the registered rx_valid so both pulse in the same cycle.
module uart_seq_trig_rx
  import uart_trig_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SEQ_LEN   = 2,
  parameter int BAUD_W    = 16,
  parameter int PARITY_EN = 0
) (
  input logic                clk,
  input logic                rst,
  uart_seq_trig_rx_if.slave  io_bus
);

  localparam int POS_W = $clog2(SEQ_LEN + 1);

  logic [DATA_BITS-1:0] w_data;
  logic                 w_valid, w_frame_err, w_parity_err;
  logic [SEQ_LEN-1:0]   w_hit;
  logic                 w_cur, w_trig;
  logic [POS_W-1:0]     r_seq_pos, w_seq_pos_n;

  uart_rx_core #(
    .DATA_BITS (DATA_BITS),
    .BAUD_W    (BAUD_W),
    .PARITY_EN (PARITY_EN)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (io_bus.RX),
    .i_baud_cnt   (io_bus.baud_cnt),
    .i_parity_odd (io_bus.parity_odd),
    .o_data       (w_data),
    .o_valid      (w_valid),
    .o_frame_err  (w_frame_err),
    .o_parity_err (w_parity_err)
  );

  always_comb begin
    w_hit = '0;
    w_cur = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      w_hit[i] = (w_data | io_bus.mask[i*DATA_BITS +: DATA_BITS]) ==
                 (io_bus.match[i*DATA_BITS +: DATA_BITS] | io_bus.mask[i*DATA_BITS +: DATA_BITS]);
      if (r_seq_pos == POS_W'(i)) w_cur = w_hit[i];
    end
  end

  // A mismatching character may still restart the sequence as element 0.
  always_comb begin
    w_seq_pos_n = r_seq_pos;
    w_trig      = 1'b0;
    if (!io_bus.arm || w_frame_err || w_parity_err) begin
      w_seq_pos_n = '0;
    end else if (w_valid) begin
      if (w_cur) begin
        if (r_seq_pos == POS_W'(SEQ_LEN - 1)) begin
          w_trig      = 1'b1;
          w_seq_pos_n = '0;
        end else begin
          w_seq_pos_n = r_seq_pos + POS_W'(1);
        end
      end else if (w_hit[0]) begin
        if (SEQ_LEN == 1) begin
          w_trig      = 1'b1;
          w_seq_pos_n = '0;
        end else begin
          w_seq_pos_n = POS_W'(1);
        end
      end else begin
        w_seq_pos_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_seq_pos <= '0;
    else     r_seq_pos <= w_seq_pos_n;
  end

  assign io_bus.rx_data    = w_data;
  assign io_bus.rx_valid   = w_valid;
  assign io_bus.frame_err  = w_frame_err;
  assign io_bus.parity_err = w_parity_err;
  assign io_bus.seq_pos    = r_seq_pos;
  assign io_bus.UARTtrig   = w_trig;

endmodule

// File: tb/tb_uart_seq_trig_rx.sv
// Directed bench: dut0 without parity (sequence, mask, arm, glitch, break),
// dut1 with even parity (parity error and mid-frame reset).
module tb_uart_seq_trig_rx;
  import uart_trig_pkg::*;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_seq_trig_rx_if #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16)) bus0 ();
  uart_seq_trig_rx_if #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16)) bus1 ();

  uart_seq_trig_rx #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .io_bus(bus0)
  );
  uart_seq_trig_rx #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .io_bus(bus1)
  );

  int assertCount = 0;
  int failCount   = 0;
  int v0 = 0, t0 = 0, tv0 = 0, f0 = 0, p0 = 0;
  int v1 = 0, f1 = 0, p1 = 0;
  int bv, bt, btv, bf, bp;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus0.rx_valid)                   v0++;
    if (bus0.UARTtrig)                   t0++;
    if (bus0.UARTtrig && bus0.rx_valid)  tv0++;
    if (bus0.frame_err)                  f0++;
    if (bus0.parity_err)                 p0++;
    if (bus1.rx_valid)                   v1++;
    if (bus1.frame_err)                  f1++;
    if (bus1.parity_err)                 p1++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic level, input int cycles);
    if (which == 0) bus0.RX = level;
    else            bus1.RX = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic sendFrame(input int which, input logic [7:0] data, input logic stopBit,
                           input logic usePar, input logic parBit);
    applyStimulus(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) applyStimulus(which, data[i], BIT);
    if (usePar) applyStimulus(which, parBit, BIT);
    applyStimulus(which, stopBit, BIT);
  endtask

  task automatic snap0();
    bv = v0; bt = t0; btv = tv0; bf = f0; bp = p0;
  endtask

  initial begin
    rst = 1'b1;
    bus0.RX = 1'b1; bus0.baud_cnt = 16'd16; bus0.parity_odd = PAR_EVEN; bus0.arm = 1'b1;
    bus0.match = {8'hA5, 8'h55}; bus0.mask = '0;
    bus1.RX = 1'b1; bus1.baud_cnt = 16'd16; bus1.parity_odd = PAR_EVEN; bus1.arm = 1'b1;
    bus1.match = {8'hA5, 8'h55}; bus1.mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_rx_data",   32'(bus0.rx_data), 32'h0);
    checkOutput("rst_rx_valid",  32'(bus0.rx_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(bus0.frame_err), 32'h0);
    checkOutput("rst_par_err",   32'(bus0.parity_err), 32'h0);
    checkOutput("rst_seq_pos",   32'(bus0.seq_pos), 32'h0);
    checkOutput("rst_trig",      32'(bus0.UARTtrig), 32'h0);
    checkOutput("rst_state",     32'(dut0.u_core.r_state), 32'(IDLE));

    $display("[TB] test 1: 0x55 then 0xA5");
    snap0();
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t1_pos_after_55", 32'(bus0.seq_pos), 32'd1);
    checkOutput("t1_trig_after_55", 32'(t0 - bt), 32'd0);
    sendFrame(0, 8'hA5, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t1_pos_after_a5", 32'(bus0.seq_pos), 32'd0);
    checkOutput("t1_trig_count",   32'(t0 - bt), 32'd1);
    checkOutput("t1_trig_w_valid", 32'(tv0 - btv), 32'd1);
    checkOutput("t1_valid_count",  32'(v0 - bv), 32'd2);
    checkOutput("t1_rx_data",      32'(bus0.rx_data), 32'hA5);

    $display("[TB] test 2: 0x55 0x55 0xA5");
    snap0();
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t2_pos1", 32'(bus0.seq_pos), 32'd1);
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t2_pos2", 32'(bus0.seq_pos), 32'd1);
    checkOutput("t2_no_trig_yet", 32'(t0 - bt), 32'd0);
    sendFrame(0, 8'hA5, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t2_pos3", 32'(bus0.seq_pos), 32'd0);
    checkOutput("t2_trig", 32'(t0 - bt), 32'd1);

    $display("[TB] test 3: masked element 1, then disarmed");
    bus0.mask = {8'h0F, 8'h00};
    snap0();
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    sendFrame(0, 8'hAF, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t3_mask_trig", 32'(t0 - bt), 32'd1);
    checkOutput("t3_rx_data",   32'(bus0.rx_data), 32'hAF);
    bus0.arm = 1'b0;
    snap0();
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t3_disarm_pos", 32'(bus0.seq_pos), 32'd0);
    sendFrame(0, 8'hAF, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t3_disarm_valid", 32'(v0 - bv), 32'd2);
    checkOutput("t3_disarm_trig",  32'(t0 - bt), 32'd0);

    $display("[TB] test 4: 4-cycle glitch");
    bus0.arm = 1'b1;
    bus0.mask = '0;
    snap0();
    applyStimulus(0, 1'b0, 4);
    applyStimulus(0, 1'b1, 24);
    checkOutput("t4_glitch_valid", 32'(v0 - bv), 32'd0);
    checkOutput("t4_glitch_ferr",  32'(f0 - bf), 32'd0);
    checkOutput("t4_glitch_state", 32'(dut0.u_core.r_state), 32'(IDLE));
    sendFrame(0, 8'h55, 1'b1, 1'b0, 1'b0); applyStimulus(0, 1'b1, BIT);
    checkOutput("t4_after_valid", 32'(v0 - bv), 32'd1);
    checkOutput("t4_after_data",  32'(bus0.rx_data), 32'h55);
    checkOutput("t4_after_pos",   32'(bus0.seq_pos), 32'd1);

    $display("[TB] test 5: bad stop bit then break");
    snap0();
    sendFrame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 40 * BIT);
    checkOutput("t5_ferr_count", 32'(f0 - bf), 32'd1);
    checkOutput("t5_no_valid",   32'(v0 - bv), 32'd0);
    checkOutput("t5_no_perr",    32'(p0 - bp), 32'd0);
    checkOutput("t5_pos",        32'(bus0.seq_pos), 32'd0);
    applyStimulus(0, 1'b1, 2 * BIT);
    checkOutput("t5_ferr_after_release", 32'(f0 - bf), 32'd1);

    $display("[TB] test 6: parity error and mid-frame reset");
    bv = v1; bf = f1; bp = p1;
    sendFrame(1, 8'h55, 1'b1, 1'b1, 1'b1); applyStimulus(1, 1'b1, BIT);
    checkOutput("t6_perr_count", 32'(p1 - bp), 32'd1);
    checkOutput("t6_perr_valid", 32'(v1 - bv), 32'd0);
    checkOutput("t6_perr_ferr",  32'(f1 - bf), 32'd0);
    sendFrame(1, 8'h55, 1'b1, 1'b1, 1'b0); applyStimulus(1, 1'b1, BIT);
    checkOutput("t6_good_valid", 32'(v1 - bv), 32'd1);
    checkOutput("t6_good_data",  32'(bus1.rx_data), 32'h55);
    checkOutput("t6_good_pos",   32'(bus1.seq_pos), 32'd1);
    bv = v1; bf = f1; bp = p1;
    applyStimulus(1, 1'b0, BIT);
    applyStimulus(1, 1'b1, BIT);
    applyStimulus(1, 1'b0, BIT);
    applyStimulus(1, 1'b1, BIT);
    rst = 1'b1;
    bus1.RX = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_data",  32'(bus1.rx_data), 32'h0);
    checkOutput("t6_rst_valid", 32'(bus1.rx_valid), 32'h0);
    checkOutput("t6_rst_ferr",  32'(bus1.frame_err), 32'h0);
    checkOutput("t6_rst_perr",  32'(bus1.parity_err), 32'h0);
    checkOutput("t6_rst_pos",   32'(bus1.seq_pos), 32'h0);
    checkOutput("t6_rst_trig",  32'(bus1.UARTtrig), 32'h0);
    checkOutput("t6_rst_state", 32'(dut1.u_core.r_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1'b1, 200);
    checkOutput("t6_abort_valid", 32'(v1 - bv), 32'd0);
    checkOutput("t6_abort_ferr",  32'(f1 - bf), 32'd0);
    checkOutput("t6_abort_perr",  32'(p1 - bp), 32'd0);
    sendFrame(1, 8'hA5, 1'b1, 1'b1, 1'b0); applyStimulus(1, 1'b1, BIT);
    checkOutput("t6_next_valid", 32'(v1 - bv), 32'd1);
    checkOutput("t6_next_data",  32'(bus1.rx_data), 32'hA5);
    checkOutput("t6_next_perr",  32'(p1 - bp), 32'd0);
    checkOutput("t6_next_pos",   32'(bus1.seq_pos), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_seq_trig_rx.md
Name: uart_seq_trig_rx

Overview:
- Parametrised successor to the single-byte UART trigger receiver, for the logic-analyser trigger path.
- Deserialises asynchronous RX frames with configurable data width and optional parity, and reports framing and parity errors.
- Fires a one-cycle trigger when a programmable sequence of SEQ_LEN masked characters arrives back-to-back.
- Sits between the external RX pin and the trigger-combine logic; match, mask and baud settings come from the config register file.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
SEQ_LEN, 2, number of characters in the trigger sequence (1..4)
BAUD_W, 16, width of baud_cnt
PARITY_EN, 0, 1 = one parity bit follows the data bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
RX  in  1  asynchronous serial input, idles high
baud_cnt  in  BAUD_W  clocks per bit; must be >= 4
parity_odd  in  1  0 = even parity, 1 = odd; ignored when PARITY_EN=0
arm  in  1  enables the sequence matcher
match  in  SEQ_LEN*DATA_BITS  expected characters; element i at [i*DATA_BITS +: DATA_BITS]; element 0 is received first
mask  in  SEQ_LEN*DATA_BITS  per-bit don't-care; 1 = ignore that bit
rx_data  out  DATA_BITS  last good character, held until the next one
rx_valid  out  1  one-cycle pulse: good character received
frame_err  out  1  one-cycle pulse: stop bit sampled low
parity_err  out  1  one-cycle pulse: parity mismatch
seq_pos  out  $clog2(SEQ_LEN+1)  number of sequence elements matched so far
UARTtrig  out  1  one-cycle pulse: full sequence matched

Behaviour:
- Reset is synchronous and active-high on clk, and has priority over every other event.
- Reset values: sync flops 1, state IDLE, all outputs 0, seq_pos 0.
- Reset mid-frame abandons the frame and produces no pulses.
- Input synchronisation: RX passes through 2 flops (rx_s); rx_p holds the previous rx_s for edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a falling edge (rx_p=1, rx_s=0). On that edge baud_cnt is latched into baud_l; changes to baud_cnt mid-frame have no effect until the next frame.
- START: counter runs 0..baud_l/2-1 (integer division).
  - At the terminal count, rx_s is sampled.
  - rx_s=1: glitch; return to IDLE with no pulse.
  - rx_s=0: go to DATA and clear the counter.
- DATA: one sample every baud_l cycles (counter 0..baud_l-1, sample at the terminal count). Samples shift into a DATA_BITS register LSB first. After DATA_BITS samples go to PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit. Error if XOR(data, sampled bit) != parity_odd.
- STOP: sample one bit, then return to IDLE in the next cycle. All pulses assert in the cycle after the stop sample:
  - stop=0: frame_err=1.
  - else parity error: parity_err=1.
  - else: rx_valid=1 and rx_data updated.
  - frame_err and parity_err may both pulse together; rx_valid is then 0.
- A held-low break line produces exactly one frame_err; IDLE requires a fresh falling edge before the next frame starts.
- Element i matches when (data | mask[i]) == (match[i] | mask[i]).
- Matcher, on a good character while arm=1:
  - If the character matches element seq_pos:
    - seq_pos = SEQ_LEN-1: UARTtrig=1, coincident with rx_valid; seq_pos returns to 0.
    - otherwise: seq_pos increments.
  - On mismatch: if the character matches element 0, seq_pos=1 (or UARTtrig=1 when SEQ_LEN=1); otherwise seq_pos=0.
- frame_err or parity_err forces seq_pos to 0.
- arm=0 holds seq_pos at 0 and blocks UARTtrig; the receiver still runs and rx_valid still pulses.
- Minimum latency from the RX stop-bit centre to UARTtrig: 2 sync cycles + 1 cycle.

Decomposition:
- Package uart_trig_pkg: rx_state_t enum, and a PAR_EVEN/PAR_ODD localparam pair.
- One sub-module, uart_rx_core: synchroniser, FSM, baud/bit counters and parity check.
  - Exports data, valid, frame_err and parity_err.
- The top level holds the masked sequence matcher and seq_pos.

Test Plan:
1. DATA_BITS=8, SEQ_LEN=2, baud_cnt=16, match={0xA5,0x55}, mask=0, arm=1; send 0x55 then 0xA5 -> seq_pos goes 1 then 0; one UARTtrig pulse with rx_valid, rx_data=0xA5.
2. Send 0x55, 0x55, 0xA5 -> seq_pos 1,1,0; UARTtrig on the third character only.
3. mask element 1 = 0x0F; send 0x55 then 0xAF -> UARTtrig=1. Repeat with arm=0 -> rx_valid pulses twice, UARTtrig stays 0.
4. 4-cycle low glitch on RX with baud_cnt=16 -> no pulses, FSM back in IDLE; a following valid 0x55 is received correctly.
5. 0x55 sent with stop bit low, then RX held low for 40 bit times -> exactly one frame_err, seq_pos=0, no rx_valid.
6. PARITY_EN=1, parity_odd=0; send 0x55 with parity 1 -> parity_err pulse. Assert rst mid-DATA -> all outputs 0 next cycle; next frame received normally.
